// File: rtl/lc4_div_defs_pkg.sv
// Shared definitions for the LC4 sequential divider: state encodings, data width,
// and the carry-out recovery used on every cla16 subtraction.
// No clocked logic; combinational helper only.
package lc4_div_defs;

  localparam int DIV_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // cla16 exposes only the sum, so the bit-16 carry of a + b + 1 is rebuilt
  // from bit 15: the carry into bit 15 is sum ^ a ^ b, then c16 = g15 | p15&c15.
  function automatic logic sub_carry(input logic a15, input logic b15, input logic s15);
    logic c15;
    c15 = s15 ^ a15 ^ b15;
    return (a15 & b15) | ((a15 | b15) & c15);
  endfunction

endpackage

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups with a lookahead
// carry chain between groups. Purely combinational, no handshake.
// Only the sum is produced; callers needing the carry-out rebuild it from bit 15.
module cla16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum
);

  logic [14:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gc;

  // Group generate of one 4-bit slice.
  function automatic logic grp_g(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  assign w_g = i_a[14:0] & i_b[14:0];
  assign w_p = i_a ^ i_b;

  // Carry into each 4-bit group.
  always_comb begin
    w_gc    = '0;
    w_gc[0] = i_cin;
    w_gc[1] = grp_g(w_g[3:0],   w_p[3:0])   | ((&w_p[3:0])   & w_gc[0]);
    w_gc[2] = grp_g(w_g[7:4],   w_p[7:4])   | ((&w_p[7:4])   & w_gc[1]);
    w_gc[3] = grp_g(w_g[11:8],  w_p[11:8])  | ((&w_p[11:8])  & w_gc[2]);
  end

  for (genvar j = 0; j < 4; j++) begin : g_grp
    assign w_c[4*j]   = w_gc[j];
    assign w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_gc[j]);
    assign w_c[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j])
                      | (w_p[4*j+1] & w_p[4*j] & w_gc[j]);
    assign w_c[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                      | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                      | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_gc[j]);
  end

  assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/lc4_div_step.sv
// One restoring-division step: shift Q's MSB into R, trial-subtract the divisor.
// Combinational, zero latency; chained by the top for several steps per clock.
// No handshake; the caller decides when the step result is registered.
module lc4_div_step
  import lc4_div_defs::*;
(
  input  logic [DIV_W-1:0] i_rem,
  input  logic [DIV_W-1:0] i_quo,
  input  logic [DIV_W-1:0] i_divisor,
  output logic [DIV_W-1:0] o_rem,
  output logic [DIV_W-1:0] o_quo
);

  logic [DIV_W:0]   w_t;
  logic [DIV_W-1:0] w_nd;
  logic [DIV_W-1:0] w_diff;
  logic             w_c16;
  logic             w_ok;

  assign w_t  = {i_rem, i_quo[DIV_W-1]};
  assign w_nd = ~i_divisor;

  cla16 u_cla (
    .i_a   (w_t[DIV_W-1:0]),
    .i_b   (w_nd),
    .i_cin (1'b1),
    .o_sum (w_diff)
  );

  // T[16] set means T exceeds 16 bits, so it is certainly >= divisor.
  assign w_c16 = sub_carry(w_t[DIV_W-1], w_nd[DIV_W-1], w_diff[DIV_W-1]);
  assign w_ok  = w_t[DIV_W] | w_c16;

  assign o_rem = w_ok ? w_diff : w_t[DIV_W-1:0];
  assign o_quo = {i_quo[DIV_W-2:0], w_ok};

endmodule

// File: rtl/lc4_seq_divider.sv
// Multi-cycle unsigned 16/16 restoring divider; STEPS_PER_CYCLE in {1,2,4}.
// Latency 16/STEPS_PER_CYCLE cycles from accept to out_valid (1 cycle for early exit).
// One op in flight: in_ready only when idle; result held until out_ready. LC4_DIV_EARLY_EXIT_EN enables early exit.
module lc4_seq_divider
  import lc4_div_defs::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIV_W-1:0] i_dividend,
  input  logic [DIV_W-1:0] i_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIV_W-1:0] o_quotient,
  output logic [DIV_W-1:0] o_remainder
);

  localparam int N_CYC = DIV_W / STEPS_PER_CYCLE;
  localparam int CNT_W = $clog2(N_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_rem;
  logic [DIV_W-1:0] r_quo;
  logic [DIV_W-1:0] r_divisor;
  logic [DIV_W-1:0] w_fin_q;
  logic [DIV_W-1:0] w_fin_r;

  logic [DIV_W-1:0] w_rem_ch [STEPS_PER_CYCLE+1];
  logic [DIV_W-1:0] w_quo_ch [STEPS_PER_CYCLE+1];

  assign w_rem_ch[0] = r_rem;
  assign w_quo_ch[0] = r_quo;

  for (genvar s = 0; s < STEPS_PER_CYCLE; s++) begin : g_step
    lc4_div_step u_step (
      .i_rem     (w_rem_ch[s]),
      .i_quo     (w_quo_ch[s]),
      .i_divisor (r_divisor),
      .o_rem     (w_rem_ch[s+1]),
      .o_quo     (w_quo_ch[s+1])
    );
  end

`ifdef LC4_DIV_EARLY_EXIT_EN
  logic             r_early;
  logic [DIV_W-1:0] w_cmp_diff;
  logic             w_zero;
  logic             w_lt;
  logic             w_early;

  cla16 u_cmp (
    .i_a   (i_dividend),
    .i_b   (~i_divisor),
    .i_cin (1'b1),
    .o_sum (w_cmp_diff)
  );

  assign w_zero  = (i_divisor == '0);
  assign w_lt    = ~sub_carry(i_dividend[DIV_W-1], ~i_divisor[DIV_W-1], w_cmp_diff[DIV_W-1]);
  assign w_early = w_zero | w_lt;
`endif

  // Final result on the terminal BUSY cycle; a zero divisor always yields 0/0.
  always_comb begin
    w_fin_q = w_quo_ch[STEPS_PER_CYCLE];
    w_fin_r = w_rem_ch[STEPS_PER_CYCLE];
`ifdef LC4_DIV_EARLY_EXIT_EN
    // r_quo still holds the untouched dividend on an early-exit op.
    if (r_early) begin
      w_fin_q = '0;
      w_fin_r = r_quo;
    end
`endif
    if (r_divisor == '0) begin
      w_fin_q = '0;
      w_fin_r = '0;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
`ifdef LC4_DIV_EARLY_EXIT_EN
      r_early     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_state   <= ST_BUSY;
            in_ready  <= 1'b0;
            r_quo     <= i_dividend;
            r_divisor <= i_divisor;
            r_rem     <= '0;
`ifdef LC4_DIV_EARLY_EXIT_EN
            // Early exit spends a single BUSY cycle by starting at terminal count.
            r_cnt     <= w_early ? CNT_LAST : '0;
            r_early   <= w_early;
`else
            r_cnt     <= '0;
`endif
          end
        end
        ST_BUSY: begin
          r_rem <= w_rem_ch[STEPS_PER_CYCLE];
          r_quo <= w_quo_ch[STEPS_PER_CYCLE];
          if (r_cnt == CNT_LAST) begin
            r_state     <= ST_DONE;
            r_cnt       <= '0;
            out_valid   <= 1'b1;
            o_quotient  <= w_fin_q;
            o_remainder <= w_fin_r;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state   <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc4_seq_divider.sv
// Self-checking bench for lc4_seq_divider: a STEPS=1 instance for directed
// vectors and corner sequences, a STEPS=4 instance for random pairs.
module tb_lc4_seq_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       iv, ir, ov, ordy;
  logic [15:0]      dvd [2];
  logic [15:0]      dvs [2];
  logic [1:0][15:0] quo, rem;

  lc4_seq_divider #(.STEPS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .i_dividend(dvd[0]), .i_divisor(dvs[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .o_quotient(quo[0]), .o_remainder(rem[0])
  );

  lc4_seq_divider #(.STEPS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .i_dividend(dvd[1]), .i_divisor(dvs[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .o_quotient(quo[1]), .o_remainder(rem[1])
  );

  typedef struct { logic [15:0] a, b, q, r; } vec_t;
  typedef struct { logic [15:0] q, r; } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endfunction

  // Expected accept-to-valid latency in clock edges.
  function automatic int exp_lat(logic [15:0] a, logic [15:0] b, int steps);
`ifdef LC4_DIV_EARLY_EXIT_EN
    if (b == 16'd0 || a < b) return 1;
`endif
    if (a == b && steps == 0) return 0;
    return 16 / steps;
  endfunction

  task automatic issue(input int u, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input string nm);
    for (int k = 0; k < 50 && !ir[u]; k++) begin
      @(posedge clk); #1;
    end
    if (!ir[u]) chk({nm, " in_ready timeout"}, 0, 1);
    dvd[u] = a;
    dvs[u] = b;
    iv[u]  = 1'b1;
    sb.push_back('{q: eq, r: er});
    @(posedge clk); #1;
    iv[u]  = 1'b0;
    dvd[u] = 16'hDEAD;
    dvs[u] = 16'h0BAD;
  endtask

  task automatic finish_op(input int u, input int lat_exp, input string nm, input bit retire);
    int   lat;
    exp_t e;
    lat = 0;
    while (!ov[u] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, ov[u] ? lat : -1, lat_exp);
    if (sb.size() == 0) begin
      chk({nm, " scoreboard empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      if (ov[u]) begin
        chk({nm, " quotient"},  quo[u], e.q);
        chk({nm, " remainder"}, rem[u], e.r);
      end
    end
    if (retire) begin
      ordy[u] = 1'b1;
      @(posedge clk); #1;
      ordy[u] = 1'b0;
      chk({nm, " out_valid after handshake"}, ov[u], 0);
      chk({nm, " in_ready after handshake"},  ir[u], 1);
    end
  endtask

  vec_t tbl [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, want summary line");
    $fatal(1);
  end

  initial begin
    logic [15:0] a, b, eq, er;
    int          mode;

    tbl[0] = '{a: 16'd100,   b: 16'd7,      q: 16'd14,     r: 16'd2};
    tbl[1] = '{a: 16'hFFFF,  b: 16'd1,      q: 16'hFFFF,   r: 16'd0};
    tbl[2] = '{a: 16'hFFFF,  b: 16'hFFFF,   q: 16'd1,      r: 16'd0};
    tbl[3] = '{a: 16'd1234,  b: 16'd0,      q: 16'd0,      r: 16'd0};
    tbl[4] = '{a: 16'd0,     b: 16'd3,      q: 16'd0,      r: 16'd0};
    tbl[5] = '{a: 16'd3,     b: 16'd10,     q: 16'd0,      r: 16'd3};
    tbl[6] = '{a: 16'h8000,  b: 16'd3,      q: 16'd10922,  r: 16'd2};
    tbl[7] = '{a: 16'hFFFE,  b: 16'hFFFF,   q: 16'd0,      r: 16'hFFFE};
    tbl[8] = '{a: 16'd1000,  b: 16'd10,     q: 16'd100,    r: 16'd0};
    tbl[9] = '{a: 16'hFFFF,  b: 16'd2,      q: 16'h7FFF,   r: 16'd1};

    iv = '0; ordy = '0;
    for (int u = 0; u < 2; u++) begin
      dvd[u] = '0;
      dvs[u] = '0;
    end

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("reset in_ready u%0d", u),  ir[u],  1);
      chk($sformatf("reset out_valid u%0d", u), ov[u],  0);
      chk($sformatf("reset quotient u%0d", u),  quo[u], 0);
      chk($sformatf("reset remainder u%0d", u), rem[u], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors on the one-step-per-cycle instance.
    for (int i = 0; i < 10; i++) begin
      issue(0, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, $sformatf("vec%0d", i));
      finish_op(0, exp_lat(tbl[i].a, tbl[i].b, 1), $sformatf("vec%0d", i), 1'b1);
    end

    // Back-pressure: result held 10 cycles while a stray in_valid is ignored.
    issue(0, 16'd100, 16'd7, 16'd14, 16'd2, "hold");
    finish_op(0, exp_lat(16'd100, 16'd7, 1), "hold", 1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        iv[0] = 1'b1; dvd[0] = 16'd999; dvs[0] = 16'd3;
      end else begin
        iv[0] = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("hold q c%0d", c),         quo[0], 14);
      chk($sformatf("hold r c%0d", c),         rem[0], 2);
      chk($sformatf("hold in_ready c%0d", c),  ir[0],  0);
      chk($sformatf("hold out_valid c%0d", c), ov[0],  1);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    chk("hold release out_valid", ov[0], 0);
    chk("hold release in_ready",  ir[0], 1);
    @(posedge clk); #1;
    chk("stray input not captured", ir[0], 1);

    // Reset mid-operation at BUSY cycle 8, then a fresh operation.
    issue(0, 16'd1000, 16'd3, 16'd333, 16'd1, "abort");
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("abort still busy", ov[0], 0);
    rst_n = 1'b0;
    #1;
    chk("abort in_ready",  ir[0],  1);
    chk("abort out_valid", ov[0],  0);
    chk("abort quotient",  quo[0], 0);
    chk("abort remainder", rem[0], 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 16'd50, 16'd5, 16'd10, 16'd0, "post_abort");
    finish_op(0, exp_lat(16'd50, 16'd5, 1), "post_abort", 1'b1);

    // Random pairs on the four-steps-per-cycle instance.
    for (int i = 0; i < 3000; i++) begin
      mode = $urandom_range(0, 7);
      a = 16'($urandom);
      if (mode == 0)      b = 16'd0;
      else if (mode < 3)  b = 16'($urandom_range(1, 255));
      else if (mode == 3) b = a;
      else                b = 16'($urandom);
      if (b == 16'd0) begin
        eq = 16'd0;
        er = 16'd0;
      end else begin
        eq = a / b;
        er = a % b;
      end
      issue(1, a, b, eq, er, $sformatf("rnd%0d %0h/%0h", i, a, b));
      finish_op(1, exp_lat(a, b, 4), $sformatf("rnd%0d %0h/%0h", i, a, b), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
